// File: rtl/stdp_pair_if.sv
// stdp_pair_if: spike inputs and weight-update outputs of the STDP pair learner
// master drives pre_spike/post_spike/learn_en; slave returns weight, time_diff, update_w_flag, ltp
interface stdp_pair_if;
  logic pre_spike;
  logic post_spike;
  logic learn_en;
  logic [7:0] weight;
  logic [7:0] time_diff;
  logic update_w_flag;
  logic ltp;
  modport master(output pre_spike, post_spike, learn_en, input weight, time_diff, update_w_flag, ltp);
  modport slave(input pre_spike, post_spike, learn_en, output weight, time_diff, update_w_flag, ltp);
endinterface

// File: rtl/stdp_pair_learner.sv
// stdp_pair_learner: nearest-neighbour pre/post interval measurement with bounded 8-bit STDP weight update
// ports: clk, rst_n (async active-low), s (stdp_pair_if.slave: spikes + learn_en in; weight, time_diff, update_w_flag, ltp out)
// STDP_DEPRESS_EN: when defined, post-first pairings (POST_SEEN) produce LTD; otherwise only pre->post potentiation exists
module stdp_pair_learner #(
  parameter int WINDOW = 16,
  parameter int DW_SHIFT = 2,
  parameter int W_INIT = 64,
  parameter int W_MAX = 255
) (
  input logic clk,
  input logic rst_n,
  stdp_pair_if.slave s
);
  typedef enum logic [1:0] {IDLE, PRE_SEEN, POST_SEEN, UPDATE} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, weight_q, weight_d, time_diff_q, time_diff_d;
  logic flag_q, flag_d, ltp_q, ltp_d;
  logic pre, post;
  logic [8:0] delta;
  logic [9:0] w_up;
  logic signed [9:0] w_dn;
  assign pre = s.pre_spike;
  assign post = s.post_spike;
  // time_diff never exceeds WINDOW, so the difference is non-negative
  assign delta = 9'((WINDOW - int'(time_diff_q)) >> DW_SHIFT) + 9'd1;
  assign w_up = {2'b0, weight_q} + {1'b0, delta};
  assign w_dn = signed'({2'b0, weight_q}) - signed'({1'b0, delta});
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    weight_d = weight_q;
    time_diff_d = time_diff_q;
    flag_d = 1'b0;
    ltp_d = ltp_q;
    case (state_q)
      PRE_SEEN: begin
        if (post) begin
          time_diff_d = cnt_q;
          ltp_d = 1'b1;
          state_d = UPDATE;
        end else if (pre) cnt_d = 8'd1;
        else if (cnt_q == 8'(WINDOW)) state_d = IDLE;
        else cnt_d = cnt_q + 8'd1;
      end
`ifdef STDP_DEPRESS_EN
      POST_SEEN: begin
        if (pre) begin
          time_diff_d = cnt_q;
          ltp_d = 1'b0;
          state_d = UPDATE;
        end else if (post) cnt_d = 8'd1;
        else if (cnt_q == 8'(WINDOW)) state_d = IDLE;
        else cnt_d = cnt_q + 8'd1;
      end
`endif
      default: begin
        // UPDATE applies the pending step, then samples spikes exactly like IDLE
        if (state_q == UPDATE) begin
          flag_d = 1'b1;
          if (s.learn_en) weight_d = ltp_q ? (w_up > 10'(W_MAX) ? 8'(W_MAX) : w_up[7:0]) : (w_dn < 0 ? 8'd0 : w_dn[7:0]);
        end
        state_d = IDLE;
        cnt_d = 8'd0;
        if (pre && !post) begin
          state_d = PRE_SEEN;
          cnt_d = 8'd1;
        end
`ifdef STDP_DEPRESS_EN
        if (post && !pre) begin
          state_d = POST_SEEN;
          cnt_d = 8'd1;
        end
`endif
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      weight_q <= 8'(W_INIT);
      time_diff_q <= 8'd0;
      flag_q <= 1'b0;
      ltp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      weight_q <= weight_d;
      time_diff_q <= time_diff_d;
      flag_q <= flag_d;
      ltp_q <= ltp_d;
    end
  end
  assign s.weight = weight_q;
  assign s.time_diff = time_diff_q;
  assign s.update_w_flag = flag_q;
  assign s.ltp = ltp_q;
endmodule

// File: doc/stdp_pair_learner.md
# stdp_pair_learner

Spike-timing measurement and weight-update stage sitting directly downstream of the two LIF neurons in the STDP demo. It consumes the presynaptic and postsynaptic spike pulses and measures the nearest-neighbour pre/post interval. It applies a bounded potentiation or depression step to an 8-bit synaptic weight and emits a one-cycle update strobe for the top level and the display path.

## Interface
- `WINDOW`, 16: pairing window in cycles. Allowed range 2..255.
- `DW_SHIFT`, 2: delta attenuation shift.
- `W_INIT`, 64: weight value loaded on reset.
- `W_MAX`, 255: upper weight saturation bound. The lower bound is 0.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pre_spike` in 1: presynaptic spike. One-cycle pulse, sampled each edge.
- `post_spike` in 1: postsynaptic spike. One-cycle pulse, sampled each edge.
- `learn_en` in 1: when low, the weight is frozen. Measurement and strobe still run.
- `weight` out 8: current synaptic weight, registered.
- `time_diff` out 8: interval dt of the last pairing, registered.
- `update_w_flag` out 1: one-cycle strobe, registered.
- `ltp` out 1: polarity of the last pairing. 1 = potentiation, 0 = depression.

## Operation
- States: IDLE, PRE_SEEN, POST_SEEN, UPDATE. Internal counter `cnt` is 8 bits.
- IDLE:
  - pre only -> PRE_SEEN, `cnt`<=1.
  - post only -> POST_SEEN, `cnt`<=1.
  - pre and post in the same cycle -> discarded (dt=0), stay in IDLE.
- PRE_SEEN:
  - post sampled -> `time_diff`<=`cnt`, pending polarity = LTP, go to UPDATE. This holds even if pre is also high in that cycle; the coincident pre is dropped.
  - pre only -> restart, `cnt`<=1 (nearest-neighbour rule).
  - no spike and `cnt`==WINDOW -> IDLE (timeout).
  - otherwise `cnt`<=`cnt`+1.
- POST_SEEN: mirror of PRE_SEEN with the roles of pre and post swapped; the pairing has polarity LTD.
- UPDATE (one cycle):
  - delta = ((WINDOW − `time_diff`) >> DW_SHIFT) + 1. Compute it at 9 bits; no wrap is allowed.
  - LTP: `weight`<=min(`weight`+delta, W_MAX).
  - LTD: `weight`<=max(`weight`−delta, 0), computed signed with no underflow.
  - If `learn_en`=0 at this edge, `weight` is held.
  - `update_w_flag`<=1 and `ltp`<=polarity.
  - Spikes sampled in this cycle are evaluated exactly as in IDLE, which sets the next state. The pairing that just completed is never re-used.
- `update_w_flag` is low in every cycle except the one following the UPDATE edge.
- Reset, including mid-pairing, asynchronously forces:
  - `weight`=W_INIT, `time_diff`=0, `update_w_flag`=0, `ltp`=0;
  - state=IDLE, `cnt`=0.
  - Any pending pairing is lost.

## Timing
- Pairing interval: first spike sampled at edge P, second at edge P+d, which gives dt=d, with 1≤d≤WINDOW.
  - `time_diff` and `ltp` pending become valid after edge P+d.
  - `weight` takes its new value after edge P+d+1.
  - `update_w_flag` is high between edges P+d+1 and P+d+2.
- Latency from the second spike to the weight change is 2 edges.
- Maximum pairing throughput is one pairing every 2 cycles.
- A second spike at exactly `cnt`==WINDOW pairs with dt=WINDOW (delta=1). At WINDOW+1 the window has already timed out, so that spike starts a new pairing.
- `learn_en` is sampled only at the UPDATE edge.

## Configuration
- `STDP_DEPRESS_EN`:
  - Defined: full behaviour, with POST_SEEN and LTD as described above.
  - Undefined: POST_SEEN is removed.
    - A post in IDLE is ignored.
    - A pre after a post causes no update.
    - `ltp` is always 1 after the first update.
    - The weight never decreases.

## Test plan
- Reset asserted mid-PRE_SEEN -> `weight`=64, `time_diff`=0, flag=0 immediately; no update follows after release.
- pre at edge 10, post at edge 13 -> `time_diff`=3, `ltp`=1 after edge 13; `weight` 64→68 and flag high for exactly one cycle after edge 14.
- With `STDP_DEPRESS_EN`: post at edge 10, pre at edge 15 -> dt=5, delta=3, `weight` 64→61, `ltp`=0.
- pre and post together in IDLE -> no flag and `weight` unchanged.
- pre at edge 10, then post at edge 27 -> timeout at edge 26 and POST_SEEN entered at edge 27, so no update occurs.
- Weight preset to 253 with pairing dt=1 (delta=4) -> saturates at 255. The same pairing with `learn_en`=0 -> flag pulses, `time_diff`=1, `weight` unchanged.
